// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int AW_DEFAULT    = 8;
    localparam int DW_DEFAULT    = 16;
    localparam int DEPTH_DEFAULT = 2;

    // Opcode in the top three instruction bits that marks a halt instruction.
    localparam logic [2:0] HALT_OPCODE = 3'b111;

    // Fetch controller states.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs. The head entry is read straight
// out of the storage registers, so the outputs carry no path from the push
// data. clear has priority over push and pop.
module fetch_queue #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [AW-1:0]    push_pc,
    input  logic [DW-1:0]    push_instr,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [AW-1:0]    head_pc,
    output logic [DW-1:0]    head_instr
);

    logic [AW-1:0]    pc_mem    [DEPTH];
    logic [DW-1:0]    instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pops on an empty queue and pushes into a full one are ignored.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && (count != CNT_W'(DEPTH));
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequences fetch addresses to a shared single-port
// RAM, tracks the one read in flight, and buffers returned instructions in a
// small prefetch queue. A slot is reserved for every in-flight read so the
// return can always be queued.
//
// Handshake: the head entry moves to the consumer on any cycle where
// instr_valid and instr_ready are both high; instr_valid never depends on
// instr_ready, and a ready without valid has no effect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] start_pc,
    input  logic          flush,
    input  logic [AW-1:0] flush_pc,
    input  logic          halt,
    input  logic          ram_busy,
    output logic          fetch_req,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    output fetch_state_t  dbg_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    logic [AW-1:0]    fetch_pc;
    logic             inflight;
    logic [AW-1:0]    inflight_pc;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             q_push;
    logic             q_pop;

    // Issue decision from the current state and this cycle's inputs.
    always_comb begin
        occupancy = {1'b0, q_count} + (CNT_W + 1)'(inflight);
        issue     = (state == RUN) && !halt && !ram_busy && !flush &&
                    (occupancy < (CNT_W + 1)'(DEPTH));
        q_push    = inflight && !flush;
        q_pop     = instr_valid && instr_ready && !flush;
    end

    assign fetch_req  = issue;
    assign ram_r_addr = fetch_pc;
    assign dbg_state  = state;

    // Controller FSM, fetch PC and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            // A flush never issues, so this also drops any in-flight read.
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (flush) begin
                state    <= RUN;
                fetch_pc <= flush_pc;
            end else begin
                case (state)
                    INIT: begin
                        fetch_pc <= start_pc;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (issue) begin
                            fetch_pc <= fetch_pc + AW'(1);
                        end
                        if (halt) begin
                            state <= HALTED;
                        end
                    end
                    HALTED: begin
                        state <= HALTED;
                    end
                    default: begin
                        state <= INIT;
                    end
                endcase
            end
        end
    end

    fetch_queue #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .push       (q_push),
        .push_pc    (inflight_pc),
        .push_instr (ram_r_data),
        .pop        (q_pop),
        .count      (q_count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

endmodule
